// File: rtl/vcve2_pkg.sv
// Shared vcve2 types and constants for the PMP CSR block and the PMP checker.
package vcve2_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
  localparam logic [11:0] CSR_MSECCFG  = 12'h747;
  localparam logic [11:0] CSR_MSECCFGH = 12'h757;

  function automatic logic [7:0] pmp_cfg_to_byte(pmp_cfg_t cfg);
    return {cfg.lock, 2'b00, cfg.mode, cfg.exec, cfg.write, cfg.read};
  endfunction

  // Mask with the low 'bits' bits set.
  function automatic logic [31:0] pmp_low_mask(int unsigned bits);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (k < bits) mask[k] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/vcve2_pmp_cfg_legalise.sv
// WARL legalisation of one pmpcfg entry byte: returns the value to store given the old entry.
module vcve2_pmp_cfg_legalise
  import vcve2_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0
) (
  input  pmp_cfg_t   i_cfg_old,
  input  logic [7:0] i_wdata,
  input  logic       i_mml,
  input  logic       i_rlb,
  output pmp_cfg_t   o_cfg_new
);

  logic          w_locked;
  logic          w_mml_lx;
  pmp_cfg_mode_e w_mode;
  logic          w_unused_rsvd;

  assign w_unused_rsvd = ^i_wdata[6:5];

  always_comb begin
    w_locked = i_cfg_old.lock & ~i_rlb;
    // Under MML a new locked executable rule may not be created without RLB.
    w_mml_lx = i_mml & ~i_rlb & i_wdata[7] & i_wdata[2];
    w_mode   = pmp_cfg_mode_e'(i_wdata[4:3]);
    if ((PMPGranularity > 0) && (w_mode == PMP_MODE_NA4)) w_mode = PMP_MODE_OFF;

    o_cfg_new = i_cfg_old;
    if (!w_locked && !w_mml_lx) begin
      o_cfg_new.lock  = i_wdata[7];
      o_cfg_new.mode  = w_mode;
      o_cfg_new.exec  = i_wdata[2];
      o_cfg_new.write = i_mml ? i_wdata[1] : (i_wdata[1] & i_wdata[0]);
      o_cfg_new.read  = i_wdata[0];
    end
  end

endmodule

// File: rtl/vcve2_pmp_csr.sv
// PMP CSR register file (pmpcfg/pmpaddr/mseccfg) feeding vcve2_pmp.
// mseccfg is implemented only when VCVE2_PMP_SMEPMP_EN is defined.
module vcve2_pmp_csr
  import vcve2_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  priv_lvl_e    priv_mode_i,
  input  logic         csr_access_i,
  input  logic         csr_we_i,
  input  logic [11:0]  csr_addr_i,
  input  logic [31:0]  csr_wdata_i,
  output logic [31:0]  csr_rdata_o,
  output logic         csr_hit_o,
  output logic         csr_illegal_o,
  output pmp_cfg_t     csr_pmp_cfg_o [PMPNumRegions],
  output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
  output pmp_mseccfg_t csr_pmp_mseccfg_o,
  output logic         pmp_updated_o
);

  localparam logic [31:0] LowMask   = pmp_low_mask(PMPGranularity);
  localparam logic [31:0] NapotOnes = pmp_low_mask((PMPGranularity > 0) ? PMPGranularity - 1 : 0);

  pmp_cfg_t     r_cfg       [PMPNumRegions];
  pmp_cfg_t     w_cfg_d     [PMPNumRegions];
  pmp_cfg_t     w_cfg_legal [PMPNumRegions];
  logic [31:0]  r_addr      [PMPNumRegions];
  logic [31:0]  w_addr_d    [PMPNumRegions];
  logic [31:0]  w_addr_rb   [PMPNumRegions];
  pmp_mseccfg_t w_mseccfg;
  logic         w_msec_changed;
  logic         r_updated;

  logic w_is_cfg, w_is_addr, w_is_msec, w_is_msech;
  logic w_hit, w_illegal, w_commit, w_changed;
  logic [PMPNumRegions-1:0] w_lk, w_tor_lk, w_cfg_we, w_addr_we;
  logic [31:0] w_rdata;

  assign w_is_cfg   = (csr_addr_i[11:2] == CSR_PMPCFG0[11:2]);
  assign w_is_addr  = (csr_addr_i[11:4] == CSR_PMPADDR0[11:4]);
  assign w_is_msec  = (csr_addr_i == CSR_MSECCFG);
  assign w_is_msech = (csr_addr_i == CSR_MSECCFGH);
  assign w_hit      = w_is_cfg | w_is_addr | w_is_msec | w_is_msech;
  assign w_illegal  = w_hit & (priv_mode_i != PRIV_LVL_M);
  assign w_commit   = csr_access_i & csr_we_i & w_hit & ~w_illegal;

  for (genvar i = 0; i < PMPNumRegions; i++) begin : g_entry
    assign w_lk[i] = r_cfg[i].lock & ~w_mseccfg.rlb;

    // A locked TOR entry also protects the address below it.
    if (i + 1 < PMPNumRegions) begin : g_tor
      assign w_tor_lk[i] = w_lk[i+1] & (r_cfg[i+1].mode == PMP_MODE_TOR);
    end else begin : g_last
      assign w_tor_lk[i] = 1'b0;
    end

    vcve2_pmp_cfg_legalise #(
      .PMPGranularity(PMPGranularity)
    ) u_legalise (
      .i_cfg_old(r_cfg[i]),
      .i_wdata  (csr_wdata_i[8*(i%4) +: 8]),
      .i_mml    (w_mseccfg.mml),
      .i_rlb    (w_mseccfg.rlb),
      .o_cfg_new(w_cfg_legal[i])
    );

    assign w_cfg_we[i]  = w_commit & w_is_cfg & (csr_addr_i[1:0] == 2'(i / 4));
    assign w_addr_we[i] = w_commit & w_is_addr & (csr_addr_i[3:0] == 4'(i)) &
                          ~w_lk[i] & ~w_tor_lk[i];
    assign w_cfg_d[i]   = w_cfg_we[i] ? w_cfg_legal[i] : r_cfg[i];
    assign w_addr_d[i]  = w_addr_we[i] ? csr_wdata_i : r_addr[i];

    // Readback hides the sub-granule bits; the stored value is left intact.
    assign w_addr_rb[i] = (r_cfg[i].mode == PMP_MODE_NAPOT) ? (r_addr[i] | NapotOnes) :
                          (r_cfg[i].mode == PMP_MODE_NA4)   ? r_addr[i] :
                                                              (r_addr[i] & ~LowMask);

    assign csr_pmp_cfg_o[i]  = r_cfg[i];
    assign csr_pmp_addr_o[i] = {r_addr[i], 2'b00};
  end

`ifdef VCVE2_PMP_SMEPMP_EN
  pmp_mseccfg_t r_mseccfg;
  pmp_mseccfg_t w_mseccfg_d;
  logic         w_any_lock;

  always_comb begin
    w_any_lock = 1'b0;
    for (int unsigned i = 0; i < PMPNumRegions; i++) begin
      if (r_cfg[i].lock) w_any_lock = 1'b1;
    end
    w_mseccfg_d = r_mseccfg;
    if (w_commit && w_is_msec) begin
      w_mseccfg_d.mml  = r_mseccfg.mml | csr_wdata_i[0];
      w_mseccfg_d.mmwp = r_mseccfg.mmwp | csr_wdata_i[1];
      if (!(csr_wdata_i[2] && !r_mseccfg.rlb && w_any_lock)) w_mseccfg_d.rlb = csr_wdata_i[2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_mseccfg <= '0;
    else         r_mseccfg <= w_mseccfg_d;
  end

  assign w_mseccfg      = r_mseccfg;
  assign w_msec_changed = (w_mseccfg_d != r_mseccfg);
`else
  assign w_mseccfg      = '0;
  assign w_msec_changed = 1'b0;
`endif

  always_comb begin
    w_changed = w_msec_changed;
    for (int unsigned i = 0; i < PMPNumRegions; i++) begin
      if ((w_cfg_d[i] != r_cfg[i]) || (w_addr_d[i] != r_addr[i])) w_changed = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < PMPNumRegions; i++) begin
        r_cfg[i]  <= '0;
        r_addr[i] <= '0;
      end
      r_updated <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < PMPNumRegions; i++) begin
        r_cfg[i]  <= w_cfg_d[i];
        r_addr[i] <= w_addr_d[i];
      end
      r_updated <= w_changed;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_cfg) begin
      for (int unsigned i = 0; i < PMPNumRegions; i++) begin
        if (csr_addr_i[1:0] == 2'(i / 4)) w_rdata[8*(i%4) +: 8] = pmp_cfg_to_byte(r_cfg[i]);
      end
    end else if (w_is_addr) begin
      for (int unsigned i = 0; i < PMPNumRegions; i++) begin
        if (csr_addr_i[3:0] == 4'(i)) w_rdata = w_addr_rb[i];
      end
    end else if (w_is_msec) begin
      w_rdata = {29'b0, w_mseccfg};
    end
  end

  assign csr_rdata_o       = w_rdata;
  assign csr_hit_o         = w_hit;
  assign csr_illegal_o     = w_illegal;
  assign csr_pmp_mseccfg_o = w_mseccfg;
  assign pmp_updated_o     = r_updated;

endmodule

// File: doc/vcve2_pmp_csr.md
# vcve2_pmp_csr

PMP configuration register file for the vcve2 core: holds pmpcfg/pmpaddr/mseccfg state, applies WARL legalisation and lock rules on M-mode CSR writes, and drives the `csr_pmp_*` inputs of the PMP checker `vcve2_pmp` directly. It sits between the CSR access decoder and `vcve2_pmp`. It also signals the fetch/LSU logic when PMP state has changed.

## Interface
Parameters:
- PMPGranularity, 0, NAPOT granule exponent; must match `vcve2_pmp`.
- PMPNumRegions, 4, implemented entries; range 1..16.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; **synchronous, active-low**; the only clock is clk_i.
- priv_mode_i  in  priv_lvl_e  current privilege.
- csr_access_i  in  1  CSR instruction in flight.
- csr_we_i  in  1  write strobe, qualified by csr_access_i.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  32  write data.
- csr_rdata_o  out  32  read data, combinational.
- csr_hit_o  out  1  address decodes to a PMP CSR.
- csr_illegal_o  out  1  hit with priv_mode_i != M.
- csr_pmp_cfg_o  out  pmp_cfg_t[PMPNumRegions]  to checker.
- csr_pmp_addr_o  out  34 x PMPNumRegions  {pmpaddr, 2'b00}.
- csr_pmp_mseccfg_o  out  pmp_mseccfg_t  to checker.
- pmp_updated_o  out  1  one-cycle pulse after an effective state change.

## Operation
- Decoded addresses:
  - pmpcfg0-3 at 0x3A0-0x3A3, 4 entry bytes each.
  - pmpaddr0-15 at 0x3B0-0x3BF, 32-bit address[33:2].
  - mseccfg 0x747; mseccfgh 0x757 reads 0, ignores writes.
- Unimplemented entries read 0 and ignore writes.
- Cfg byte layout: {L, 2'b0, A[1:0], X, W, R}. Each byte of a pmpcfg write is legalised independently:
  - W is stored as W&R when mml=0.
  - A=NA4 is stored as OFF when PMPGranularity>0.
- Entry lock: lk[i] = cfg[i].L & ~rlb.
  - cfg[i] write is ignored when lk[i].
  - pmpaddr[i] write is ignored when lk[i], or when lk[i+1] & cfg[i+1].A==TOR.
- With mml=1 and rlb=0, a cfg byte write with L=1 and X=1 is ignored for that byte only.
- mseccfg fields:
  - mml and mmwp are set-only until reset.
  - rlb: a write of 1 is ignored when rlb=0 and any cfg[i].L=1. A write of 0 is always accepted.
- pmpaddr readback:
  - A=NAPOT: bits [PMPGranularity-2:0] read 1.
  - A=OFF or TOR: bits [PMPGranularity-1:0] read 0.
  - The stored value is unmodified; the checker ignores those bits.
- Writes with csr_illegal_o=1 have no effect. csr_rdata_o is 0 when !csr_hit_o.

## Timing
- Write commits on the clk_i edge where csr_access_i & csr_we_i & csr_hit_o & !csr_illegal_o.
- New values appear on all csr_pmp_* outputs the following cycle. A same-cycle read returns the old value.
- pmp_updated_o is registered: high exactly one cycle after any commit that changed a stored bit. It is low for ignored or no-change writes.
- Back-to-back writes give back-to-back pulses.
- Reset, with rst_ni low at an edge:
  - All cfg, addr and mseccfg bits go to 0 and pmp_updated_o goes to 0.
  - Reset overrides a simultaneous write.
- Only one CSR is written per cycle, so there are no write collisions.

## Configuration
- VCVE2_PMP_SMEPMP_EN defined: mseccfg is implemented as described.
- Not defined:
  - mseccfg reads 0 and ignores writes; csr_pmp_mseccfg_o is tied 0.
  - The legalisation rules that depend on mml always take the mml=0 path.

## Structure
- vcve2_pkg holds:
  - pmp_cfg_t and pmp_mseccfg_t;
  - the PMP_MODE_* encodings;
  - the CSR address constants CSR_PMPCFG0, CSR_PMPADDR0, CSR_MSECCFG and CSR_MSECCFGH.
- Sub-module vcve2_pmp_cfg_legalise (combinational, one instance per entry):
  - inputs: old byte, write byte, mml, rlb, PMPGranularity;
  - output: next byte.

## Test plan
- pmpcfg0 write 0x0000_001F, then pmpcfg0 write 0x0000_0002 → entry0 {A=NAPOT,X,W,R}. The second write is stored as 0x00 (W cleared, R=0); pmp_updated_o pulses once per write.
- pmpcfg0 write 0x8F00 (entry1 L=1, TOR) → pmpaddr0 and pmpaddr1 writes ignored, no pulse; pmpcfg0 write 0x0000 leaves entry1 unchanged.
- PMPGranularity=2, pmpaddr0=0x0, entry0 NAPOT → reads 0x1. Entry0 TOR with pmpaddr0=0xFFFF_FFFF → reads 0xFFFF_FFFC.
- mseccfg write 0x3 (mml, mmwp), then write 0x0 → reads 0x3. With entry0 L=1 and rlb=0, a rlb=1 write is ignored.
- priv_mode_i=U, pmpaddr2 write → csr_illegal_o=1, value unchanged. Reset asserted during a valid write → all outputs 0 next cycle.
- With VCVE2_PMP_SMEPMP_EN undefined, mseccfg write 0x7 → reads 0 and csr_pmp_mseccfg_o stays 0.
